// File: rtl/seg_pkg.sv
// Shared nibble codes, segment glyphs and digit helpers
// for the seven-segment scan driver.
package seg_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam logic [3:0] CODE_P     = 4'hA;
  localparam logic [3:0] CODE_B     = 4'hB;
  localparam logic [3:0] CODE_L     = 4'hC;
  localparam logic [3:0] CODE_D     = 4'hD;
  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_P     = 7'h0C;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_L     = 7'h47;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [3:0] nibble_at(
    input logic [15:0] w,
    input digit_idx_t  i
  );
    logic [3:0] n;
    n = w[15:12];
    unique case (i)
      2'd0: n = w[15:12];
      2'd1: n = w[11:8];
      2'd2: n = w[7:4];
      2'd3: n = w[3:0];
    endcase
    return n;
  endfunction

  function automatic logic [3:0] digit_mask(
    input digit_idx_t i
  );
    logic [3:0] m;
    m = AN_OFF;
    unique case (i)
      2'd0: m = 4'b0111;
      2'd1: m = 4'b1011;
      2'd2: m = 4'b1101;
      2'd3: m = 4'b1110;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bundle between the print-select logic and
// the seven-segment scan driver.
interface seg_scan_driver_if;
  import seg_pkg::*;

  logic [15:0] data;
  logic        load;
  logic        blink;
  logic [3:0]  an;
  seg_t        seg;
  logic        dp;

  modport master (
    output data,
    output load,
    output blink,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  data,
    input  load,
    input  blink,
    output an,
    output seg,
    output dp
  );

endinterface

// File: rtl/seg_decoder.sv
// Nibble to active-low seven-segment glyph decoder.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    unique case (nib)
      4'h0:       seg_n = SEG_0;
      4'h1:       seg_n = SEG_1;
      4'h2:       seg_n = SEG_2;
      4'h3:       seg_n = SEG_3;
      4'h4:       seg_n = SEG_4;
      4'h5:       seg_n = SEG_5;
      4'h6:       seg_n = SEG_6;
      4'h7:       seg_n = SEG_7;
      4'h8:       seg_n = SEG_8;
      4'h9:       seg_n = SEG_9;
      CODE_P:     seg_n = SEG_P;
      CODE_B:     seg_n = SEG_B;
      CODE_L:     seg_n = SEG_L;
      CODE_D:     seg_n = SEG_D;
      CODE_DASH:  seg_n = SEG_DASH;
      CODE_BLANK: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with
// frame-synchronous updates and whole-display blink.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        load,
  input  logic        blink,
  output logic [3:0]  an,
  output seg_t        seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic [3:0]    an_q, an_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    cur_nib;
  seg_t          cur_glyph;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= 16'hFFFF;
      shadow_q    <= 16'hFFFF;
      pending_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == 2'd3);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;
  end

  // disp only moves at a frame wrap, so a scan never mixes words
  always_comb begin
    shadow_d  = load ? data : shadow_q;
    pending_d = pending_q | load;
    disp_d    = disp_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d = data;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!blink) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  assign cur_nib = nibble_at(disp_q, idx_q);

  seg_decoder u_dec (
    .nib   (cur_nib),
    .seg_n (cur_glyph)
  );

  always_comb begin
    an_d  = digit_mask(idx_q);
    seg_d = cur_glyph;
    dp_d  = 1'b1;
    if (blink && blink_off_q) begin
      an_d = AN_OFF;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised and directed checks of seg_scan_driver
// against a frame-level behavioural display model.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .data  (bus.data),
    .load  (bus.load),
    .blink (bus.blink),
    .an    (bus.an),
    .seg   (bus.seg),
    .dp    (bus.dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---- reference model: time measured in clocks since reset ----
  int          m_n;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pend;
  int          m_bframes;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
          7'h78, 7'h00, 7'h10, 7'h0C, 7'h03, 7'h47, 7'h21,
          7'h3F, 7'h7F};
    return t[v];
  endfunction

  function automatic int pos_of(input int n);
    return (n / DIV) % 4;
  endfunction

  function automatic bit wrap_at(input int n);
    return (n % FRAME) == FRAME - 1;
  endfunction

  function automatic logic [3:0] lit_mask(input int p);
    logic [3:0] m;
    m = 4'b1000 >> p;
    return ~m;
  endfunction

  function automatic logic [15:0] next_disp(input int n);
    if (!wrap_at(n)) return m_disp;
    if (bus.load) return bus.data;
    if (m_pend) return m_shadow;
    return m_disp;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n       <= 0;
      m_disp    <= 16'hFFFF;
      m_shadow  <= 16'hFFFF;
      m_pend    <= 1'b0;
      m_bframes <= 0;
      m_an      <= 4'hF;
      m_seg     <= 7'h7F;
    end else begin
      m_an  <= (bus.blink && ((m_bframes / BF) % 2 == 1))
               ? 4'hF : lit_mask(pos_of(m_n));
      m_seg <= glyph(m_disp[15 - 4 * pos_of(m_n) -: 4]);
      m_shadow <= bus.load ? bus.data : m_shadow;
      m_pend   <= wrap_at(m_n) ? 1'b0 : (m_pend | bus.load);
      m_disp   <= next_disp(m_n);
      m_bframes <= !bus.blink ? 0
                 : (wrap_at(m_n) ? m_bframes + 1 : m_bframes);
      m_n <= m_n + 1;
    end
  end

  task automatic align(input int ph);
    for (int i = 0; i < FRAME; i++) begin
      if (m_n % FRAME == ph) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold an=%b seg=%h dp=%b want 1111/7f/1",
               bus.an, bus.seg, bus.dp);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_async an=%b seg=%h dp=%b want 1111/7f/1",
               bus.an, bus.seg, bus.dp);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle;
    logic [3:0] e;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = lit_mask(((k - 1) / DIV) % 4);
      total++;
      if (bus.an !== e || bus.seg !== 7'h7F) begin
        bad++;
        $display("FAIL idle_scan k=%0d an=%b seg=%h want %b/7f",
                 k, bus.an, bus.seg, e);
      end
      total++;
      if (bus.an !== m_an || bus.dp !== 1'b1) begin
        bad++;
        $display("FAIL model_idle an=%b want %b dp=%b",
                 bus.an, m_an, bus.dp);
      end
    end
  endtask

  task automatic test_load_mid;
    logic [6:0] want [4];
    int f0, p, d;
    want = '{7'h79, 7'h0C, 7'h79, 7'h7F};
    align(DIV);
    f0 = m_n / FRAME;
    bus.data = 16'h1A1F;
    bus.load = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      p = m_n - 1;
      d = (p % FRAME) / DIV;
      total++;
      if (p / FRAME == f0 && bus.seg !== 7'h7F) begin
        bad++;
        $display("FAIL load_mid_early p=%0d seg=%h want 7f", p, bus.seg);
      end else if (p / FRAME > f0 &&
                   (bus.seg !== want[d] || bus.an !== lit_mask(d))) begin
        bad++;
        $display("FAIL load_mid_new d=%0d seg=%h an=%b want %h/%b",
                 d, bus.seg, bus.an, want[d], lit_mask(d));
      end
    end
  endtask

  task automatic test_last_wins;
    align(1);
    bus.data = 16'h1234;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    bus.data = 16'h5678;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (bus.an !== m_an || bus.dp !== 1'b1 ||
          (m_an != 4'hF && bus.seg !== m_seg)) begin
        bad++;
        $display("FAIL model_last an=%b/%b seg=%h/%h",
                 bus.an, m_an, bus.seg, m_seg);
      end
      total++;
      if (bus.seg === 7'h24 || bus.seg === 7'h30 || bus.seg === 7'h19) begin
        bad++;
        $display("FAIL last_wins_stale seg=%h want none of 24/30/19",
                 bus.seg);
      end
    end
  endtask

  task automatic test_wrap_load;
    int d;
    align(FRAME - 1);
    bus.data = 16'h0000;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      d = i / DIV;
      total++;
      if (bus.an !== lit_mask(d) || bus.seg !== 7'h40) begin
        bad++;
        $display("FAIL wrap_load d=%0d an=%b seg=%h want %b/40",
                 d, bus.an, bus.seg, lit_mask(d));
      end
      total++;
      if (bus.an !== m_an || (m_an != 4'hF && bus.seg !== m_seg)) begin
        bad++;
        $display("FAIL model_wrap an=%b/%b seg=%h/%h",
                 bus.an, m_an, bus.seg, m_seg);
      end
    end
  endtask

  task automatic test_blink;
    int base, r;
    bit dark;
    align(FRAME - 1);
    bus.data = 16'h8888;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.blink = 1'b1;
    base = m_n;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      r = m_n - 1 - base;
      dark = ((r / (BF * FRAME)) % 2) == 1;
      total++;
      if ((bus.an === 4'hF) != dark ||
          (!dark && bus.seg !== 7'h00)) begin
        bad++;
        $display("FAIL blink_phase r=%0d an=%b seg=%h dark_wanted=%0d",
                 r, bus.an, bus.seg, dark);
      end
      total++;
      if (bus.an !== m_an || (m_an != 4'hF && bus.seg !== m_seg)) begin
        bad++;
        $display("FAIL model_blink an=%b/%b seg=%h/%h",
                 bus.an, m_an, bus.seg, m_seg);
      end
    end
    bus.blink = 1'b0;
    @(negedge clk);
    total++;
    if (bus.an === 4'hF || bus.an !== m_an ||
        dut.blink_cnt_q !== '0 || dut.blink_off_q !== 1'b0) begin
      bad++;
      $display("FAIL blink_release an=%b want %b cnt=%0d off=%b want 0/0",
               bus.an, m_an, dut.blink_cnt_q, dut.blink_off_q);
    end
  endtask

  task automatic test_reset_pending;
    align(3);
    bus.data = 16'h2222;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_pend_async an=%b seg=%h dp=%b want 1111/7f/1",
               bus.an, bus.seg, bus.dp);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (bus.seg !== 7'h7F || bus.an !== m_an) begin
        bad++;
        $display("FAIL reset_pend_show an=%b/%b seg=%h want 7f",
                 bus.an, m_an, bus.seg);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      bus.load = ($urandom_range(5) == 0);
      bus.data = 16'($urandom);
      if ($urandom_range(49) == 0) bus.blink = ~bus.blink;
      @(negedge clk);
      total++;
      if (bus.an !== m_an || bus.dp !== 1'b1 ||
          (m_an != 4'hF && bus.seg !== m_seg)) begin
        bad++;
        $display("FAIL model_rand i=%0d an=%b/%b seg=%h/%h dp=%b",
                 i, bus.an, m_an, bus.seg, m_seg, bus.dp);
      end
    end
    bus.load  = 1'b0;
    bus.blink = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    bus.data  = 16'h0000;
    bus.load  = 1'b0;
    bus.blink = 1'b0;
    test_reset;
    test_idle;
    test_load_mid;
    test_last_wins;
    test_wrap_load;
    test_blink;
    test_reset_pending;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal values are 2 or more.
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 64, meaning full scan frames per blink half-period; legal values are 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data, input, 16 bits: display word, 4 nibbles, [15:12] shown leftmost (the word produced by the game's print-select logic).
REQ-006 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures data.
REQ-007 The block SHALL have port blink, input, 1 bit: level; when 1, the whole display flashes.
REQ-008 The block SHALL have port an, output, 4 bits: digit enables, active-low; an[3] is the leftmost digit.
REQ-009 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port dp, output, 1 bit: decimal point, active-low, held at 1 at all times.

Function
REQ-011 The block SHALL implement a divider counter cnt that runs 0..REFRESH_DIV-1 and then wraps; the cycle where cnt==REFRESH_DIV-1 is "tick".
REQ-012 On each tick the block SHALL increment a 2-bit idx modulo 4; idx 0,1,2,3 selects nibbles [15:12],[11:8],[7:4],[3:0] on an[3],an[2],an[1],an[0].
REQ-013 A tick where idx goes 3->0 SHALL be a "frame wrap".
REQ-014 On load the block SHALL capture data into register shadow and set pending; a later load before the frame wrap SHALL overwrite shadow (last wins).
REQ-015 At a frame wrap the display register disp SHALL be updated: disp <= data if load is active in that same cycle, else shadow if pending, else unchanged; pending SHALL clear at every frame wrap. There SHALL be no mid-frame tearing.
REQ-016 an, seg and dp SHALL be registered and reflect the current idx and disp with 1 clk of latency.
REQ-017 Exactly one an bit SHALL be 0, except while blanked (REQ-020), when an SHALL be 4'b1111.
REQ-018 Nibble decode SHALL be: 0-9 as decimal digits; A='P'; B='b'; C='L'; D='d'; E='-'; F=blank (seg=7'h7F).
REQ-019 A blink_cnt register SHALL count frame wraps 0..BLINK_FRAMES-1; on wrap it SHALL toggle blink_off.
REQ-020 While blink=1 and blink_off=1, an SHALL be 4'b1111.
REQ-021 While blink=0, blink_cnt and blink_off SHALL be held at 0, so that after any assertion of blink the display is lit for the first half-period.

Reset
REQ-022 On reset, asserted asynchronously, the block SHALL set cnt=0, idx=0, disp=shadow=16'hFFFF, pending=0, blink_cnt=0, blink_off=0, an=4'b1111, seg=7'h7F, dp=1.
REQ-023 Reset asserted mid-frame or mid-blink SHALL abandon all state, including a pending load.
REQ-024 After reset deassertion, the first tick SHALL occur REFRESH_DIV cycles later.

Structure
REQ-025 A shared package seg_pkg SHALL hold the nibble code constants (CODE_P=4'hA, CODE_B=4'hB, CODE_L=4'hC, CODE_D=4'hD, CODE_DASH=4'hE, CODE_BLANK=4'hF) and the 7-bit segment patterns.
REQ-026 Combinational nibble-to-segment decoding SHALL be a sub-module seg_decoder (4-bit in, 7-bit active-low out), instantiated once.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2 unless noted)
REQ-027 Bench SHALL cover: reset, then no load for 40 cycles -> an cycles 0111,1011,1101,1110 every 4 clks; seg stays 7'h7F.
REQ-028 Bench SHALL cover: load with data=16'h1A1F at idx=1 -> display unchanged until the next frame wrap; next frame shows '1','P','1',blank.
REQ-029 Bench SHALL cover: load 16'h1234 then 16'h5678 within one frame -> next frame shows 5,6,7,8; 1234 is never displayed.
REQ-030 Bench SHALL cover: load 16'h0000 in the exact frame-wrap cycle -> the new frame shows 0,0,0,0 immediately.
REQ-031 Bench SHALL cover: blink=1 with data 16'h8888 -> lit for 2 frames, an=1111 for 2 frames, repeating; blink=0 -> lit next cycle and blink counters zero.
REQ-032 Bench SHALL cover: reset pulsed mid-frame with pending=1 -> an=1111, seg=7'h7F in the same cycle; the pending word is never shown.
